kappa3_mem_responder: RTL and testbench



---
 rtl/kappa3_mem_responder_pkg.sv | 51 +++++
 rtl/kappa3_mem_responder_if.sv | 38 +++
 rtl/kappa3_mem_responder_byte_ram.sv | 59 +++++
 rtl/kappa3_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_kappa3_mem_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kappa3_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kappa3_mem_defs (package)
//  Description : Shared definitions for the kappa3 memory responder:
//                FSM state encoding, legal byte-lane write masks and the
//                write-mask legality helper.
//  Revision    : 1.0  initial release
// ============================================================================
package kappa3_mem_defs;

    // Responder FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAITST = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Legal write masks: single bytes, aligned halfwords, full word.
    localparam logic [3:0] c_wb_byte0   = 4'b0001;
    localparam logic [3:0] c_wb_byte1   = 4'b0010;
    localparam logic [3:0] c_wb_byte2   = 4'b0100;
    localparam logic [3:0] c_wb_byte3   = 4'b1000;
    localparam logic [3:0] c_wb_half_lo = 4'b0011;
    localparam logic [3:0] c_wb_half_hi = 4'b1100;
    localparam logic [3:0] c_wb_word    = 4'b1111;

    // Width of the wait-state counter (WAIT is limited to 0..15).
    localparam int c_cnt_bits = 4;

    // A write mask is legal when it is one of the listed shapes; halfword
    // masks must additionally agree with the byte offset of the address.
    // Byte and word writes ignore addr_lo because addressing is word based.
    function automatic logic wrbits_legal(input logic [3:0] wrbits,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (wrbits)
            c_wb_byte0, c_wb_byte1,
            c_wb_byte2, c_wb_byte3,
            c_wb_word:    ok = 1'b1;
            c_wb_half_lo: ok = (addr_lo == 2'b00);
            c_wb_half_hi: ok = (addr_lo == 2'b10);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kappa3_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : kappa3_mem_responder_if
//  Description : Memory-phase bus between the kappa3 datapath (master) and
//                the memory responder (slave).
//                mem_addr    byte address
//                mem_read    read request level
//                mem_write   write request level
//                mem_wrbits  byte-lane write enables, bit i <-> byte i
//                mem_wrdata  write data, lanes already positioned
//                mem_rddata  registered read word
//                mem_ready   one-cycle completion pulse
//                mem_busy    high from acceptance through the ready cycle
//                mem_err     qualifies mem_ready; request was rejected
//  Revision    : 1.0  initial release
// ============================================================================
interface kappa3_mem_responder_if;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wrbits, mem_wrdata,
        input  mem_rddata, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wrbits, mem_wrdata,
        output mem_rddata, mem_ready, mem_busy, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/kappa3_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module      : kappa3_byte_ram
//  Description : Single-port synchronous RAM of 2^ADDR_BITS 32-bit words,
//                organised as four independent byte lanes with individual
//                write enables and a registered read word.
//                clock    rising-edge clock
//                reset    synchronous, active-high; clears the read register
//                addr     word address
//                wr_en    per-lane write enable
//                rd_en    load the read register from the addressed word
//                rd_clr   force the read register to zero
//                wrdata   write data, byte i feeds lane i
//                rddata   registered read word
//  Revision    : 1.0  initial release
// ============================================================================
module kappa3_byte_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [3:0]           wr_en,
    input  logic                 rd_en,
    input  logic                 rd_clr,
    input  logic [31:0]          wrdata,
    output logic [31:0]          rddata
);

    localparam int c_depth = 1 << ADDR_BITS;

    // One storage array per byte lane keeps each lane's write port simple
    // and lets the lanes be written independently in the same cycle.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_mem [c_depth];
        logic [7:0] r_rd_byte;

        // Storage is never reset; contents survive a responder reset.
        always_ff @(posedge clock) begin
            if (wr_en[i]) begin
                lane_mem[addr] <= wrdata[8*i +: 8];
            end
        end

        // The read register only moves on an explicit read or clear, so the
        // word seen by the requester holds across writes and idle cycles.
        always_ff @(posedge clock) begin
            if (reset || rd_clr) begin
                r_rd_byte <= 8'h00;
            end else if (rd_en) begin
                r_rd_byte <= lane_mem[addr];
            end
        end

        assign rddata[8*i +: 8] = r_rd_byte;
    end

endmodule
`default_nettype wire

// File: rtl/kappa3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : kappa3_mem_responder
//  Description : Memory-side responder for the kappa3 multi-cycle core.
//                Latches a read or write request, waits WAIT cycles,
//                performs the access on an internal byte-lane RAM and
//                answers with a one-cycle ready pulse (plus error flag).
//                After responding it waits for both strobes to drop so a
//                held strobe cannot trigger a second access.
//                clock    rising-edge clock
//                reset    synchronous, active-high
//                mem      slave side of kappa3_mem_responder_if
//  Revision    : 1.0  initial release
// ============================================================================
module kappa3_mem_responder
    import kappa3_mem_defs::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int WAIT      = 2     // legal range 0..15
) (
    input  logic                   clock,
    input  logic                   reset,
    kappa3_mem_responder_if.slave  mem
);

    // Counter preload: WAITST is left on the edge where the counter is 0,
    // so WAIT-1 yields exactly WAIT cycles in WAITST.
    localparam logic [c_cnt_bits-1:0] c_wait_load =
        (WAIT == 0) ? '0 : c_cnt_bits'(WAIT - 1);

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_bits-1:0] r_cnt;
    logic [c_cnt_bits-1:0] w_cnt_nxt;
    logic                  w_accept;

    logic [31:0]           r_addr;
    logic [31:0]           r_wrdata;
    logic [3:0]            r_wrbits;
    logic                  r_op_rd;
    logic                  r_op_wr;

    logic                  r_ready;
    logic                  r_err;
    logic                  r_busy;

    // ------------------------------------------------------------------
    // Error classification on the latched request
    // ------------------------------------------------------------------
    logic w_addr_bad;
    logic w_conflict;
    logic w_mask_bad;
    logic w_err;

    // Any set bit above the word-address field puts the access out of range.
    assign w_addr_bad = ((r_addr >> (ADDR_BITS + 2)) != 32'd0);
    assign w_conflict = r_op_rd && r_op_wr;
    assign w_mask_bad = r_op_wr && !wrbits_legal(r_wrbits, r_addr[1:0]);
    assign w_err      = w_addr_bad || w_conflict || w_mask_bad;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem.mem_read || mem.mem_write) begin
                    w_accept = 1'b1;
                    if (mem.mem_read && mem.mem_write) begin
                        // Conflicting strobes are rejected without wait states.
                        w_state_nxt = ST_ACCESS;
                    end else if (WAIT == 0) begin
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_WAITST;
                        w_cnt_nxt   = c_wait_load;
                    end
                end
            end

            ST_WAITST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            ST_ACCESS: w_state_nxt = ST_RESP;

            ST_RESP:   w_state_nxt = ST_HOLD;

            ST_HOLD: begin
                if (!mem.mem_read && !mem.mem_write) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= 32'd0;
            r_wrdata <= 32'd0;
            r_wrbits <= 4'd0;
            r_op_rd  <= 1'b0;
            r_op_wr  <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Inputs are captured once; later changes on the bus do not
            // affect the access in flight.
            if (w_accept) begin
                r_addr   <= mem.mem_addr;
                r_wrdata <= mem.mem_wrdata;
                r_wrbits <= mem.mem_wrbits;
                r_op_rd  <= mem.mem_read;
                r_op_wr  <= mem.mem_write;
            end

            // Outputs are decoded from the next state so they line up with
            // the state they describe.
            r_ready <= (w_state_nxt == ST_RESP);
            r_err   <= (w_state_nxt == ST_RESP) && w_err;
            r_busy  <= (w_state_nxt == ST_WAITST) ||
                       (w_state_nxt == ST_ACCESS) ||
                       (w_state_nxt == ST_RESP);
        end
    end

    // ------------------------------------------------------------------
    // RAM port control, active only during the ACCESS cycle
    // ------------------------------------------------------------------
    logic                 w_in_access;
    logic [3:0]           w_ram_we;
    logic                 w_ram_re;
    logic                 w_ram_clr;
    logic [31:0]          w_ram_rddata;
    logic [ADDR_BITS-1:0] w_ram_addr;

    assign w_in_access = (r_state == ST_ACCESS);
    assign w_ram_addr  = r_addr[ADDR_BITS+1:2];

    // Reset on the ACCESS exit edge must still discard the write.
    assign w_ram_we  = (w_in_access && r_op_wr && !w_err && !reset) ?
                       r_wrbits : 4'b0000;
    assign w_ram_re  = w_in_access && r_op_rd && !w_err;
    // A rejected read (including a read/write conflict) returns zero; a
    // rejected write leaves the read word untouched.
    assign w_ram_clr = w_in_access && r_op_rd && w_err;

    kappa3_byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .addr   (w_ram_addr),
        .wr_en  (w_ram_we),
        .rd_en  (w_ram_re),
        .rd_clr (w_ram_clr),
        .wrdata (r_wrdata),
        .rddata (w_ram_rddata)
    );

    assign mem.mem_rddata = w_ram_rddata;
    assign mem.mem_ready  = r_ready;
    assign mem.mem_err    = r_err;
    assign mem.mem_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_kappa3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kappa3_mem_responder
//  Description : Self-checking bench for kappa3_mem_responder. Two
//                instances are exercised: WAIT=2 (dut) and WAIT=0 (dut0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_kappa3_mem_responder;

    localparam int c_wait = 2;

    logic clock;
    logic reset;

    kappa3_mem_responder_if bif ();
    kappa3_mem_responder_if bif0 ();

    kappa3_mem_responder #(.ADDR_BITS(10), .WAIT(c_wait)) dut (
        .clock (clock),
        .reset (reset),
        .mem   (bif)
    );

    kappa3_mem_responder #(.ADDR_BITS(10), .WAIT(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .mem   (bif0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wb;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int s, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] wb, input logic [31:0] d);
        if (s == 0) begin
            bif.mem_read = rd; bif.mem_write = wr; bif.mem_addr = a;
            bif.mem_wrbits = wb; bif.mem_wrdata = d;
        end else begin
            bif0.mem_read = rd; bif0.mem_write = wr; bif0.mem_addr = a;
            bif0.mem_wrbits = wb; bif0.mem_wrdata = d;
        end
    endtask

    function automatic logic o_ready(input int s);
        return (s == 0) ? bif.mem_ready : bif0.mem_ready;
    endfunction
    function automatic logic o_err(input int s);
        return (s == 0) ? bif.mem_err : bif0.mem_err;
    endfunction
    function automatic logic o_busy(input int s);
        return (s == 0) ? bif.mem_busy : bif0.mem_busy;
    endfunction
    function automatic logic [31:0] o_rd(input int s);
        return (s == 0) ? bif.mem_rddata : bif0.mem_rddata;
    endfunction

    // One complete transaction: issue, wait for ready (bounded), drop the
    // strobes in the ready cycle, observe the HOLD cycle, return to IDLE.
    task automatic access(input int s, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] wb, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rdv,
                          output logic hold_ok);
        @(negedge clock);
        drive(s, rd, wr, a, wb, d);
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!o_ready(s) && lat < 40);
        err = o_err(s);
        rdv = o_rd(s);
        drive(s, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h5A5A_5A5A);
        @(posedge clock);
        @(negedge clock);
        hold_ok = !o_busy(s) && !o_ready(s) && !o_err(s);
        @(posedge clock);
    endtask

    task automatic run_check(input string name, input int s, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [3:0] wb, input logic [31:0] d,
                             input logic exp_err, input logic [31:0] exp_rd, input logic check_rd);
        int          lat;
        int          exp_lat;
        logic        err;
        logic [31:0] rdv;
        logic        hold_ok;
        access(s, rd, wr, a, wb, d, lat, err, rdv, hold_ok);
        exp_lat = (rd && wr) ? 2 : (((s == 0) ? c_wait : 0) + 2);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " err"}, {31'd0, err}, {31'd0, exp_err});
        if (check_rd) chk({name, " rddata"}, rdv, exp_rd);
        chk({name, " hold"}, {31'd0, hold_ok}, 32'd1);
    endtask

    // Behavioural reference: decides rejection from the request alone.
    function automatic logic model_err(input logic rd, input logic wr, input logic [31:0] a,
                                       input logic [3:0] wb);
        logic bad;
        bad = 1'b0;
        if (a >= 32'h0000_1000) bad = 1'b1;       // 1024 words * 4 bytes
        if (rd && wr) bad = 1'b1;
        if (wr && !rd) begin
            case (wb)
                4'h1, 4'h2, 4'h4, 4'h8, 4'hF: ;
                4'h3:    if (a[1:0] != 2'd0) bad = 1'b1;
                4'hC:    if (a[1:0] != 2'd2) bad = 1'b1;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    logic [31:0] model_mem [2][16];

    initial begin
        int          pulses;
        int          busy_cnt;
        logic        known;
        logic [31:0] exp_rd;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

        // --- reset state --------------------------------------------------
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            chk("reset ready", {31'd0, o_ready(s)}, 32'd0);
            chk("reset err", {31'd0, o_err(s)}, 32'd0);
            chk("reset busy", {31'd0, o_busy(s)}, 32'd0);
            chk("reset rddata", o_rd(s), 32'd0);
        end
        reset = 1'b0;
        @(posedge clock);

        // --- directed vector table (WAIT=2 instance) ---------------------
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0011, 4'h2, 32'h0000_AA00, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'h1122_AA44};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0013, 4'hC, 32'hFFFF_0000, 1'b1, 32'h1122_AA44};
        vecs[7]  = '{1'b0, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h1122_AA44};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'h1122_AA44};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0012, 4'hC, 32'hBEEF_0000, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'hBEEF_AA44};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0010, 4'h5, 32'h1234_5678, 1'b1, 32'hBEEF_AA44};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 1'b1, 32'hBEEF_AA44};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'hBEEF_AA44};
        vecs[16] = '{1'b0, 1'b1, 32'h0000_0013, 4'h1, 32'h0000_0077, 1'b0, 32'hBEEF_AA44};
        vecs[17] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'hBEEF_AA77};
        vecs[18] = '{1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[19] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 1'b0, 32'hBEEF_AA77};

        for (int i = 0; i < 20; i++) begin
            run_check($sformatf("vec%0d", i), 0, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                      vecs[i].wb, vecs[i].data, vecs[i].exp_err, vecs[i].exp_rd, 1'b1);
        end

        // --- held read strobe: one ready pulse only -----------------------
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        pulses   = 0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bif.mem_ready) pulses++;
            if (bif.mem_busy) busy_cnt++;
        end
        chk("held pulses", 32'(pulses), 32'd1);
        chk("held busy cycles", 32'(busy_cnt), 32'(c_wait + 2));
        chk("held rddata", bif.mem_rddata, 32'hBEEF_AA77);
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clock);
        run_check("conflict", 0, 1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);

        // --- reset during WAITST discards the write ----------------------
        run_check("pre20", 0, 1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        drive(0, 1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
        @(posedge clock);
        @(negedge clock);
        chk("waitst busy", {31'd0, bif.mem_busy}, 32'd1);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rst ready", {31'd0, bif.mem_ready}, 32'd0);
        chk("rst err", {31'd0, bif.mem_err}, 32'd0);
        chk("rst busy", {31'd0, bif.mem_busy}, 32'd0);
        chk("rst rddata", bif.mem_rddata, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        run_check("post20", 0, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b0, 32'h55AA_55AA, 1'b1);

        // --- WAIT=0 instance ----------------------------------------------
        run_check("w0 write", 1, 1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b1);
        run_check("w0 read", 1, 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b1);

        // --- randomized traffic against the reference model --------------
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                model_mem[s][w] = $urandom;
                run_check("rinit", s, 1'b0, 1'b1, 32'h100 + 32'(w * 4), 4'hF,
                          model_mem[s][w], 1'b0, 32'h0, 1'b0);
            end
            known  = 1'b0;
            exp_rd = 32'h0;
            for (int k = 0; k < 40; k++) begin
                int          op;
                int          w;
                logic        rd;
                logic        wr;
                logic        e;
                logic [31:0] a;
                logic [3:0]  wb;
                logic [31:0] d;
                op = $urandom_range(0, 9);
                w  = $urandom_range(0, 15);
                rd = (op <= 3) || (op == 9);
                wr = (op >= 4);
                a  = 32'h100 + 32'(w * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
                wb = 4'($urandom_range(0, 15));
                d  = $urandom;
                e  = model_err(rd, wr, a, wb);
                if (!e && wr) begin
                    for (int b = 0; b < 4; b++)
                        if (wb[b]) model_mem[s][w][8*b +: 8] = d[8*b +: 8];
                end
                if (rd) begin
                    exp_rd = e ? 32'h0 : model_mem[s][w];
                    known  = 1'b1;
                end
                run_check($sformatf("rand%0d_%0d", s, k), s, rd, wr, a, wb, d, e, exp_rd, known);
            end
            // read back the whole region
            for (int w = 0; w < 16; w++) begin
                run_check("rback", s, 1'b1, 1'b0, 32'h100 + 32'(w * 4), 4'h0, 32'h0,
                          1'b0, model_mem[s][w], 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
